mem_port_unit: RTL and testbench
================================

# mem_port_unit

Memory-port sequencer between the microprogrammed controller and the unified instruction/data memory. It turns the controller's single-cycle memory strobes into a req/ack bus transaction and asserts `stall`, which gates the controller's and datapath's clock enables. It owns the Instruction Register and the Memory Data Register, and records sticky access faults for the debug view.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width.
- `TIMEOUT`, 15: maximum REQ cycles without `mem_ack` before abort; range 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `IorD`  in  1  address select: 0 = `pc`, 1 = `alu_out`.
- `MemRead`  in  1  data read strobe, from the controller.
- `MemWrite`  in  1  data write strobe.
- `IRWrite`  in  1  instruction fetch strobe; also starts a read.
- `pc`  in  ADDR_W  program counter.
- `alu_out`  in  ADDR_W  ALUOut register.
- `wdata`  in  DATA_W  B register (store data).
- `inst`  out  DATA_W  Instruction Register; feeds the controller's decoder.
- `mdr`  out  DATA_W  Memory Data Register.
- `stall`  out  1  combinational; high = hold the controller state and datapath registers.
- `mem_req`, `mem_we`  out  1  bus request and write qualifier.
- `mem_addr`  out  ADDR_W  registered word-aligned address.
- `mem_wdata`  out  DATA_W  registered store data.
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.
- `fault`  out  2  sticky: 00 none, 01 misaligned, 10 timeout, 11 read+write conflict.

## Operation
- `go` = `MemRead | MemWrite | IRWrite`. `is_wr` = `MemWrite`.
- The address is `IorD ? alu_out : pc`.
- **IDLE:**
  - No `go`: `stall` = 0.
  - `go` with `MemWrite` and (`MemRead` or `IRWrite`) asserted: `fault` <= 11. No bus access, `stall` = 0.
  - `go` with address[1:0] != 0: `fault` <= 01. No access, `stall` = 0, IR/MDR unchanged.
  - Otherwise: `stall` = 1. Latch the address, `wdata`, `is_wr` and `ir_en` = `IRWrite`. Clear the timeout counter, then go to REQ.
- **REQ:**
  - `mem_req` = 1 and `mem_we` = `is_wr`. Address, data and qualifiers stay stable until the exit edge.
  - `stall` = ~`mem_ack`.
  - On `mem_ack`, read: MDR <= `mem_rdata`, and IR <= `mem_rdata` if `ir_en`. Write: no capture. Then go to IDLE.
  - No ack: the counter increments. When the counter reaches `TIMEOUT` with no ack, go to ERR.
- **ERR:**
  - One cycle with `mem_req` = 0 and `stall` = 0, then IDLE.
  - `fault` <= 10; IR and MDR unchanged.
  - The controller advances past the failed access.
- `mem_ack` outside REQ is ignored.
- `fault` keeps its first nonzero code. Later faults do not overwrite it. Only `rst` clears it.
- Counter width is clog2(`TIMEOUT`+1). It never wraps, because REQ exits at `TIMEOUT`.

## Timing
- **Reset (asynchronous, immediate):** state = IDLE, `mem_req` = `mem_we` = 0, `mem_addr` = `mem_wdata` = 0, `inst` = `mdr` = 0, `fault` = 00, counter = 0. `stall` = 0, since it follows combinationally from IDLE with its inputs.
- **Reset mid-REQ:** the transaction is abandoned with no IR/MDR update. A late `mem_ack` after reset is ignored.
- **Access latency:**
  - Cycle T: strobe seen, `stall` = 1.
  - T+1: `mem_req` = 1.
  - Ack at T+1+k: IR/MDR capture and the controller advance happen on the same edge.
  - Minimum 2 cycles per memory micro-state (k = 0).
- **Back-to-back:** a new `go` in the cycle after the ack edge is accepted normally. No dead cycle is required.
- **Timeout:** `mem_req` is high for exactly `TIMEOUT` cycles, then ERR. Total `stall` cycles = `TIMEOUT` + 1.

## Structure
- Shared package `mp_mem_pkg`: state enum (IDLE, REQ, ERR), fault code constants (`FLT_NONE`, `FLT_MISALIGN`, `FLT_TIMEOUT`, `FLT_CONFLICT`), default `TIMEOUT`.
- Single module with no sub-modules. IR, MDR and the counter are inline registers.

## Test plan
- **Fetch:** `IRWrite` = 1, `IorD` = 0, `pc` = 0x40, memory returns 0x8C220004 with ack on the 3rd REQ cycle.
  - `mem_addr` = 0x40, `stall` high for 3 cycles.
  - `inst` = `mdr` = 0x8C220004 after the ack edge.
- **Store:** `MemWrite` = 1, `IorD` = 1, `alu_out` = 0x104, `wdata` = 0xDEADBEEF, ack immediate.
  - `mem_we` = 1 and `mem_wdata` = 0xDEADBEEF for 1 cycle.
  - `inst` and `mdr` unchanged.
- **Misaligned:** `MemRead` = 1, `alu_out` = 0x102.
  - `mem_req` never rises, `fault` = 01, `stall` stays 0.
  - A later timeout leaves `fault` at 01.
- **Timeout:** `MemRead` = 1, no ack, `TIMEOUT` = 15.
  - `mem_req` high for exactly 15 cycles, `stall` high for 16 cycles.
  - `fault` = 10, `mdr` unchanged.
- **Reset mid-REQ:** assert `rst` in the 2nd REQ cycle, then pulse `mem_ack` after release.
  - `mem_req` drops immediately.
  - `inst` = `mdr` = 0, and the late ack has no effect.
- **Conflict:** `MemWrite` = `MemRead` = 1.
  - `fault` = 11, no bus activity.
  - A subsequent normal fetch completes.

Source files
------------

// File: rtl/mp_mem_pkg.sv
// Shared types and constants for the memory-port sequencer.
// Holds the sequencer state encoding, the sticky fault codes and the default abort limit.
package mp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } mp_state_e;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FLT_CONFLICT = 2'b11;

    localparam int unsigned DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_unit.sv
// Memory-port sequencer: turns controller memory strobes into a req/ack bus access,
// stalls the controller meanwhile, owns IR/MDR and records sticky access faults.
//
// state | meaning
// IDLE  | waiting for a strobe; stalls only on the cycle an access is accepted
// REQ   | bus request held; stall until mem_ack, abort to ERR after TIMEOUT cycles
// ERR   | one bus-idle cycle after a timeout; controller moves past the failed access
module mem_port_unit
    import mp_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IorD,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mp_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic              ir_en_q, ir_en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [1:0]        fault_q, fault_d;

    logic              go, conflict, misalign, accept;
    logic [ADDR_W-1:0] addr_sel;

    assign go       = MemRead | MemWrite | IRWrite;
    assign conflict = MemWrite & (MemRead | IRWrite);
    assign addr_sel = IorD ? alu_out : pc;
    assign misalign = |addr_sel[1:0];
    assign accept   = go & ~conflict & ~misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            ir_en_q <= 1'b0;
            cnt_q   <= '0;
            inst_q  <= '0;
            mdr_q   <= '0;
            fault_q <= FLT_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            ir_en_q <= ir_en_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            mdr_q   <= mdr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        ir_en_d = ir_en_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        mdr_d   = mdr_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                // Conflict takes priority over misalignment when both apply.
                if (go && conflict) begin
                    if (fault_q == FLT_NONE) fault_d = FLT_CONFLICT;
                end else if (go && misalign) begin
                    if (fault_q == FLT_NONE) fault_d = FLT_MISALIGN;
                end else if (accept) begin
                    state_d = REQ;
                    addr_d  = {addr_sel[ADDR_W-1:2], 2'b00};
                    wdata_d = wdata;
                    is_wr_d = MemWrite;
                    ir_en_d = IRWrite;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!is_wr_q) begin
                        mdr_d = mem_rdata;
                        if (ir_en_q) inst_d = mem_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = ERR;
                end
            end
            ERR: begin
                if (fault_q == FLT_NONE) fault_d = FLT_TIMEOUT;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: stall = accept;
            REQ: begin
                stall   = ~mem_ack;
                mem_req = 1'b1;
                mem_we  = is_wr_q;
            end
            default: ;
        endcase
    end

    assign inst      = inst_q;
    assign mdr       = mdr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_mem_port_unit.sv
// Directed bench for mem_port_unit: fetch, store, back-to-back, timeout, reset
// during an access, misalignment and strobe conflict, with hand-computed expectations.
module tb_mem_port_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IorD = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, IRWrite = 1'b0;
    logic [31:0] pc = '0, alu_out = '0, wdata = '0;
    logic [31:0] inst, mdr, mem_addr, mem_wdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [1:0]  fault;

    int checks = 0;
    int failures = 0;

    mem_port_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out), .wdata(wdata), .inst(inst),
        .mdr(mdr), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds MemRead without ever acking; drops it once stall falls, like the controller would.
    task automatic run_no_ack(input logic [31:0] addr, output int sc, output int rc);
        sc = 0;
        rc = 0;
        MemRead = 1'b1; IorD = 1'b0; pc = addr;
        for (int i = 0; i < 40; i++) begin
            logic s;
            #1;
            s = stall;
            if (s) sc++;
            if (mem_req) rc++;
            tick();
            if (!s) MemRead = 1'b0;
        end
        MemRead = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b%0b exp=00", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        checks++; if (inst !== 32'h0 || mdr !== 32'h0) begin failures++; $display("FAIL reset_irmdr got=%h/%h exp=0/0", inst, mdr); end
        checks++; if (fault !== 2'b00) begin failures++; $display("FAIL reset_fault got=%b exp=00", fault); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int sc = 0;
        IRWrite = 1'b1; IorD = 1'b0; pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            mem_ack   = (i == 3);
            mem_rdata = (i == 3) ? 32'h8C220004 : 32'h0;
            #1;
            if (stall) sc++;
            if (i == 1) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL fetch_req got=%0b/%h exp=1/00000040", mem_req, mem_addr); end
            end
            tick();
        end
        IRWrite = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (sc !== 3) begin failures++; $display("FAIL fetch_stall_cycles got=%0d exp=3", sc); end
        checks++; if (inst !== 32'h8C220004 || mdr !== 32'h8C220004) begin failures++; $display("FAIL fetch_capture got=%h/%h exp=8c220004", inst, mdr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_req_drop got=%0b exp=0", mem_req); end
        tick();
    endtask

    task automatic test_store();
        MemWrite = 1'b1; IorD = 1'b1; alu_out = 32'h104; wdata = 32'hDEADBEEF;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL store_stall_accept got=%0b exp=1", stall); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL store_we got=%0b%0b exp=11", mem_req, mem_we); end
        checks++; if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h104) begin failures++; $display("FAIL store_bus got=%h/%h exp=deadbeef/00000104", mem_wdata, mem_addr); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_stall_ack got=%0b exp=0", stall); end
        tick();
        MemWrite = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL store_we_drop got=%0b%0b exp=00", mem_req, mem_we); end
        checks++; if (inst !== 32'h8C220004 || mdr !== 32'h8C220004) begin failures++; $display("FAIL store_irmdr got=%h/%h exp=8c220004", inst, mdr); end
        tick();
    endtask

    task automatic test_back_to_back();
        MemRead = 1'b1; IorD = 1'b1; alu_out = 32'h200;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0; alu_out = 32'h204;
        #1;
        checks++; if (mdr !== 32'h11111111) begin failures++; $display("FAIL b2b_mdr1 got=%h exp=11111111", mdr); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%0b exp=1", stall); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h204) begin failures++; $display("FAIL b2b_req2 got=%0b/%h exp=1/00000204", mem_req, mem_addr); end
        tick();
        MemRead = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (mdr !== 32'h22222222 || inst !== 32'h8C220004) begin failures++; $display("FAIL b2b_mdr2 got=%h/%h exp=22222222/8c220004", mdr, inst); end
        tick();
    endtask

    task automatic test_timeout();
        int sc, rc;
        run_no_ack(32'h300, sc, rc);
        checks++; if (rc !== 15) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=15", rc); end
        checks++; if (sc !== 16) begin failures++; $display("FAIL timeout_stall_cycles got=%0d exp=16", sc); end
        checks++; if (fault !== 2'b10) begin failures++; $display("FAIL timeout_fault got=%b exp=10", fault); end
        checks++; if (mdr !== 32'h22222222) begin failures++; $display("FAIL timeout_mdr got=%h exp=22222222", mdr); end
    endtask

    task automatic test_reset_mid_req();
        MemRead = 1'b1; IorD = 1'b0; pc = 32'h500;
        tick();
        tick();
        rst = 1'b1; MemRead = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%0b exp=0", mem_req); end
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++; if (inst !== 32'h0 || mdr !== 32'h0) begin failures++; $display("FAIL rstmid_irmdr got=%h/%h exp=0/0", inst, mdr); end
        checks++; if (mem_req !== 1'b0 || fault !== 2'b00) begin failures++; $display("FAIL rstmid_idle got=%0b/%b exp=0/00", mem_req, fault); end
    endtask

    task automatic test_misaligned();
        int sc, rc;
        MemRead = 1'b1; IorD = 1'b1; alu_out = 32'h102;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL misalign_stall got=%0b exp=0", stall); end
        tick();
        MemRead = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL misalign_req got=%0b exp=0", mem_req); end
        checks++; if (fault !== 2'b01) begin failures++; $display("FAIL misalign_fault got=%b exp=01", fault); end
        tick();
        run_no_ack(32'h600, sc, rc);
        checks++; if (fault !== 2'b01 || rc !== 15) begin failures++; $display("FAIL misalign_sticky got=%b/%0d exp=01/15", fault, rc); end
    endtask

    task automatic test_conflict();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        MemWrite = 1'b1; MemRead = 1'b1; IorD = 1'b0; pc = 32'h700;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL conflict_stall got=%0b exp=0", stall); end
        tick();
        MemWrite = 1'b0; MemRead = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || fault !== 2'b11) begin failures++; $display("FAIL conflict_fault got=%0b/%b exp=0/11", mem_req, fault); end
        IRWrite = 1'b1; pc = 32'h80;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin failures++; $display("FAIL conflict_fetch_req got=%0b/%h exp=1/00000080", mem_req, mem_addr); end
        tick();
        IRWrite = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (inst !== 32'hCAFEF00D || fault !== 2'b11) begin failures++; $display("FAIL conflict_fetch got=%h/%b exp=cafef00d/11", inst, fault); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_req();
        test_misaligned();
        test_conflict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
